aes_inv_cipher: RTL and testbench

- Iterative AES-128 inverse cipher: one inverse round per clock, turning a 128-bit ciphertext block into plaintext.
- Decrypt-side counterpart of the encrypt ALU round datapath.
- Uses the same state packing as the forward ShiftRows path: byte 0 = bits [127:120], column-major per FIPS-197.
- Round keys are not expanded here. An external key store returns rk_data combinationally for the rk_idx this block drives.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_inv_cipher_inv_sbox.sv | 28 ++
 rtl/aes_inv_cipher.sv | 116 +++++++++++
 tb/tb_aes_inv_cipher.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types, constants and GF(2^8) helpers.
// State packing: byte 0 = bits [127:120], column-major (byte i = row i%4, col i/4).
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } inv_fsm_t;

  localparam int unsigned AES_NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  // Row r rotates right by r byte positions.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t res;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return res;
  endfunction

  // Column-wise multiply by the {0e,0b,0d,09} circulant.
  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t res;
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(r + 4*c) -: 8];
        x2    = gf_mul2(a[r]);
        x4    = gf_mul2(x2);
        x8    = gf_mul2(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      res[127 - 8*(0 + 4*c) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      res[127 - 8*(1 + 4*c) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      res[127 - 8*(2 + 4*c) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      res[127 - 8*(3 + 4*c) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_inv_sbox.sv
// 8-bit combinational AES inverse S-box lookup.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Round keys come from an external combinational key store addressed by rk_idx.
// Optional debug ports enabled by defining AES_INV_CIPHER_DBG_EN.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int unsigned NR       = AES_NR,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
`ifdef AES_INV_CIPHER_DBG_EN
  ,
  output logic [RK_IDX_W-1:0] dbg_round,
  output logic [127:0]        dbg_state
`endif
);

  localparam logic [RK_IDX_W-1:0] RK_LAST  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RK_START = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] RK_ONE   = RK_IDX_W'(1);

  inv_fsm_t              fsm_q, fsm_d;
  aes_state_t            state_q, state_d;
  aes_state_t            out_q, out_d;
  logic [RK_IDX_W-1:0]   round_q, round_d;

  aes_state_t            isr, isb, ark, imc;

  // Shared round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
  assign isr = inv_shift_rows(state_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (isr[8*(15-g) +: 8]),
      .out_o (isb[8*(15-g) +: 8])
    );
  end

  assign ark = isb ^ rk_data;
  assign imc = inv_mix_columns(ark);

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign out_data  = out_q;

`ifdef AES_INV_CIPHER_DBG_EN
  assign dbg_round = round_q;
  assign dbg_state = state_q;
`endif

  // Round-key index requested from the key store; DONE prefetches the first key.
  always_comb begin
    rk_idx = RK_LAST;
    unique case (fsm_q)
      ROUND:   rk_idx = round_q;
      FINAL:   rk_idx = '0;
      default: rk_idx = RK_LAST;
    endcase
  end

  // Next-state logic for FSM, state register, round counter and output register.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    out_d   = out_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          round_d = RK_START;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = imc;
        round_d = round_q - RK_ONE;
        if (round_q == RK_ONE) fsm_d = FINAL;
      end
      FINAL: begin
        state_d = ark;
        out_d   = ark;
        fsm_d   = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed self-checking bench for aes_inv_cipher with a behavioural key store.
module tb_aes_inv_cipher;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_INV_CIPHER_DBG_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;
`endif

  logic [127:0] rk_tbl [0:10];
  int           n_checks;
  int           n_errors;

  aes_inv_cipher #(.NR(10), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_INV_CIPHER_DBG_EN
    ,
    .dbg_round (dbg_round),
    .dbg_state (dbg_state)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? rk_tbl[rk_idx] : 128'h0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box built from the GF inverse and the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, s, r;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    s = inv ^ 8'h63;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Present one block, trace rk_idx and latency, optionally inject a stray
  // in_valid mid-block, apply backpressure for `hold` cycles, then drain.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           input int hold, input int inject_cyc, input logic [127:0] inject_ct);
    int w;
    int cyc;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin tick(); w++; end
    check({tag, " in_ready idle"}, 128'(in_ready), 128'(1));
    check({tag, " rk_idx idle"}, 128'(rk_idx), 128'(10));
    in_valid = 1'b1;
    in_data  = ct;
    tick();
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 128'(in_ready), 128'(0));
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (cyc <= 9)
        check({tag, " rk_idx trace"}, 128'(rk_idx), 128'(cyc <= 8 ? 9 - cyc : 0));
      in_valid = (cyc == inject_cyc);
      in_data  = (cyc == inject_cyc) ? inject_ct : ct;
      tick();
      in_valid = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(10));
    check({tag, " out_data"}, out_data, exp);
    check({tag, " rk_idx done"}, 128'(rk_idx), 128'(10));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold out_valid"}, 128'(out_valid), 128'(1));
      check({tag, " hold out_data"}, out_data, exp);
      check({tag, " hold in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " drained out_valid"}, 128'(out_valid), 128'(0));
    check({tag, " drained in_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int r = 0; r < 11; r++) rk_tbl[r] = '0;

    // Reset values
    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset out_data", out_data, 128'h0);
    check("reset rk_idx", 128'(rk_idx), 128'(10));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post-reset in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1
    load_key(C1_KEY);
    check("C1 rk10", rk_tbl[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_block("C1", C1_CT, C1_PT, 0, -1, '0);

    // FIPS-197 Appendix B with 5 cycles of backpressure
    load_key(B_KEY);
    check("B rk10", rk_tbl[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_block("B bp", B_CT, B_PT, 5, -1, '0);

    // Stray in_valid in ROUND is ignored
    run_block("B inject", B_CT, B_PT, 0, 3, C1_CT);
    load_key(C1_KEY);
    run_block("C1 after inject", C1_CT, C1_PT, 0, -1, '0);

    // Reset while at round 5
    in_valid = 1'b1;
    in_data  = C1_CT;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre-abort rk_idx", 128'(rk_idx), 128'(5));
    rst = 1'b1;
    #1;
    check("abort out_valid", 128'(out_valid), 128'(0));
    check("abort rk_idx", 128'(rk_idx), 128'(10));
    tick();
    rst = 1'b0;
    tick();
    check("abort in_ready", 128'(in_ready), 128'(1));
    check("abort out_valid after", 128'(out_valid), 128'(0));
    check("abort out_data cleared", out_data, 128'h0);
    run_block("C1 after abort", C1_CT, C1_PT, 0, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
